// File: rtl/mod_ten_scheduler_if.sv
// Handshake/bus bundle for mod_ten_scheduler: per-requester request/cmd/len in,
// one-hot grant, completion pulses, counter mode lines and counter mirror out.
interface mod_ten_scheduler_if #(
    parameter int LEN_W = 4
);
    logic [2:0]       req;
    logic [1:0]       cmd0;
    logic [1:0]       cmd1;
    logic [1:0]       cmd2;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [LEN_W-1:0] len2;
    logic [2:0]       gnt;
    logic [2:0]       done;
    logic             w1;
    logic             w0;
    logic             busy;
    logic [3:0]       count;
    logic             wrap;

    modport master (
        output req, cmd0, cmd1, cmd2, len0, len1, len2,
        input  gnt, done, w1, w0, busy, count, wrap
    );

    modport slave (
        input  req, cmd0, cmd1, cmd2, len0, len1, len2,
        output gnt, done, w1, w0, busy, count, wrap
    );
endinterface

// File: rtl/mod_ten_scheduler.sv
// Round-robin burst scheduler driving a shared mod-MOD counter and keeping a registered mirror of it.
// Grant one cycle after a request in IDLE; each burst ends with a one-cycle DONE before the next grant.
module mod_ten_scheduler #(
    parameter int MOD   = 10,
    parameter int LEN_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mod_ten_scheduler_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       r_winner;
    logic [1:0]       w_winner_nxt;
    logic [1:0]       r_cmd;
    logic [1:0]       w_cmd_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_nxt;
    logic [3:0]       r_count;
    logic [3:0]       w_count_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;

    logic [1:0]       w_pick;
    logic             w_pick_vld;
    logic [1:0]       w_pick_cmd;
    logic [LEN_W-1:0] w_pick_len_raw;
    logic [LEN_W-1:0] w_pick_len;
    logic [2:0]       w_gnt;
    logic [2:0]       w_done;
    logic [1:0]       w_mode;
    logic             w_busy;

    // Scan from the highest offset down so the requester nearest ptr wins.
    always_comb begin
        int idx;
        w_pick     = 2'd0;
        w_pick_vld = 1'b0;
        idx        = 0;
        for (int k = 2; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % 3;
            if (bus.req[idx]) begin
                w_pick     = 2'(idx);
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_pick_cmd     = bus.cmd0;
        w_pick_len_raw = bus.len0;
        case (w_pick)
            2'd1: begin
                w_pick_cmd     = bus.cmd1;
                w_pick_len_raw = bus.len1;
            end
            2'd2: begin
                w_pick_cmd     = bus.cmd2;
                w_pick_len_raw = bus.len2;
            end
            default: begin
                w_pick_cmd     = bus.cmd0;
                w_pick_len_raw = bus.len0;
            end
        endcase
        w_pick_len = (w_pick_len_raw == '0) ? LEN_W'(1) : w_pick_len_raw;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_winner_nxt = r_winner;
        w_cmd_nxt    = r_cmd;
        w_rem_nxt    = r_rem;
        w_gnt        = 3'b000;
        w_done       = 3'b000;
        w_mode       = 2'b00;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_winner_nxt = w_pick;
                    w_cmd_nxt    = w_pick_cmd;
                    w_rem_nxt    = w_pick_len;
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                w_gnt     = 3'b001 << r_winner;
                w_mode    = r_cmd;
                w_busy    = 1'b1;
                w_rem_nxt = r_rem - LEN_W'(1);
                // A dropped request still gets this cycle's command, then aborts.
                if ((r_rem == LEN_W'(1)) || !bus.req[r_winner]) begin
                    w_state_nxt = S_DONE;
                    w_ptr_nxt   = (r_winner == 2'd2) ? 2'd0 : r_winner + 2'd1;
                end
            end
            S_DONE: begin
                w_done      = 3'b001 << r_winner;
                w_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        case (w_mode)
            2'b01: begin
                if (r_count >= 4'(MOD - 1)) begin
                    w_count_nxt = 4'd0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count + 4'd1;
                end
            end
            2'b10: begin
                if (r_count >= 4'(MOD - 2)) begin
                    w_count_nxt = r_count - 4'(MOD - 2);
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count + 4'd2;
                end
            end
            2'b11: begin
                if (r_count == 4'd0) begin
                    w_count_nxt = 4'(MOD - 1);
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count - 4'd1;
                end
            end
            default: begin
                w_count_nxt = r_count;
                w_wrap_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd0;
            r_winner <= 2'd0;
            r_cmd    <= 2'b00;
            r_rem    <= '0;
            r_count  <= 4'd0;
            r_wrap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_winner <= w_winner_nxt;
            r_cmd    <= w_cmd_nxt;
            r_rem    <= w_rem_nxt;
            r_count  <= w_count_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    assign bus.gnt   = w_gnt;
    assign bus.done  = w_done;
    assign bus.w1    = w_mode[1];
    assign bus.w0    = w_mode[0];
    assign bus.busy  = w_busy;
    assign bus.count = r_count;
    assign bus.wrap  = r_wrap;
endmodule

// File: tb/tb_mod_ten_scheduler.sv
// Bench for mod_ten_scheduler: directed bursts plus randomized traffic, every cycle
// compared against a burst-level reference model.
module tb_mod_ten_scheduler;
    localparam int MOD   = 10;
    localparam int LEN_W = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mod_ten_scheduler_if #(.LEN_W(LEN_W)) bus ();

    mod_ten_scheduler #(.MOD(MOD), .LEN_W(LEN_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: 0 = waiting for requests, 1 = burst in progress, 2 = burst finished.
    int m_phase;
    int m_who;
    int m_left;
    int m_cmd;
    int m_ptr;
    int m_count;
    int m_wrap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cmd_of(input int who);
        case (who)
            0:       return int'(bus.cmd0);
            1:       return int'(bus.cmd1);
            default: return int'(bus.cmd2);
        endcase
    endfunction

    function automatic int len_of(input int who);
        int l;
        case (who)
            0:       l = int'(bus.len0);
            1:       l = int'(bus.len1);
            default: l = int'(bus.len2);
        endcase
        return (l == 0) ? 1 : l;
    endfunction

    task automatic model_edge();
        int sum;
        int d;
        int idx;
        bit found;
        if (rst) begin
            m_phase = 0; m_who = 0; m_left = 0; m_cmd = 0;
            m_ptr = 0; m_count = 0; m_wrap = 0;
            return;
        end
        m_wrap = 0;
        if (m_phase == 1 && m_cmd != 0) begin
            d       = (m_cmd == 1) ? 1 : (m_cmd == 2) ? 2 : -1;
            sum     = m_count + d;
            m_wrap  = (sum >= MOD || sum < 0) ? 1 : 0;
            m_count = (sum + MOD) % MOD;
        end
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    idx = (m_ptr + k) % 3;
                    if (!found && bus.req[idx]) begin
                        found   = 1'b1;
                        m_who   = idx;
                        m_cmd   = cmd_of(idx);
                        m_left  = len_of(idx);
                        m_phase = 1;
                    end
                end
            end
            1: begin
                m_left--;
                if (m_left == 0 || !bus.req[m_who]) begin
                    m_phase = 2;
                    m_ptr   = (m_who + 1) % 3;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_outputs();
        int exp_gnt;
        int exp_done;
        exp_gnt  = (m_phase == 1) ? (1 << m_who) : 0;
        exp_done = (m_phase == 2) ? (1 << m_who) : 0;
        chk("gnt",   32'(bus.gnt),   32'(exp_gnt));
        chk("done",  32'(bus.done),  32'(exp_done));
        chk("w1w0",  32'({bus.w1, bus.w0}), (m_phase == 1) ? 32'(m_cmd) : 32'd0);
        chk("busy",  32'(bus.busy),  (m_phase != 0) ? 32'd1 : 32'd0);
        chk("count", 32'(bus.count), 32'(m_count));
        chk("wrap",  32'(bus.wrap),  32'(m_wrap));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_all(input logic [1:0] c, input logic [LEN_W-1:0] l);
        bus.cmd0 = c; bus.cmd1 = c; bus.cmd2 = c;
        bus.len0 = l; bus.len1 = l; bus.len2 = l;
    endtask

    // Holds one requester for the grant cycle plus `hold` run cycles, then releases.
    task automatic burst(input int who, input logic [1:0] c, input logic [LEN_W-1:0] l, input int hold);
        set_all(c, l);
        bus.req = 3'(1 << who);
        repeat (1 + hold) step();
        bus.req = 3'b000;
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.req = 3'b000;
        set_all(2'b00, '0);
        m_phase = 0; m_who = 0; m_left = 0; m_cmd = 0;
        m_ptr = 0; m_count = 0; m_wrap = 0;

        do_reset();
        chk("rst_gnt",   32'(bus.gnt),   32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);

        burst(0, 2'b01, 4'd3, 3);
        chk("single_count", 32'(bus.count), 32'd3);

        set_all(2'b00, 4'd1);
        bus.req = 3'b111;
        repeat (12) step();
        bus.req = 3'b000;
        repeat (2) step();

        do_reset();
        burst(0, 2'b01, 4'd8, 8);
        chk("preset_count", 32'(bus.count), 32'd8);
        burst(0, 2'b10, 4'd1, 1);
        chk("wrap_up_count", 32'(bus.count), 32'd0);
        burst(0, 2'b11, 4'd1, 1);
        chk("wrap_dn_count", 32'(bus.count), 32'd9);

        burst(1, 2'b01, 4'd9, 2);
        chk("abort_count", 32'(bus.count), 32'd2);

        burst(2, 2'b00, 4'd0, 1);
        chk("hold_count", 32'(bus.count), 32'd2);

        set_all(2'b01, 4'd5);
        bus.req = 3'b001;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 3'b000;
        chk("midrst_gnt",   32'(bus.gnt),   32'd0);
        chk("midrst_done",  32'(bus.done),  32'd0);
        chk("midrst_count", 32'(bus.count), 32'd0);
        repeat (3) step();

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) bus.req = 3'($urandom_range(0, 7));
            bus.cmd0 = 2'($urandom_range(0, 3));
            bus.cmd1 = 2'($urandom_range(0, 3));
            bus.cmd2 = 2'($urandom_range(0, 3));
            bus.len0 = LEN_W'($urandom_range(0, 15));
            bus.len1 = LEN_W'($urandom_range(0, 15));
            bus.len2 = LEN_W'($urandom_range(0, 15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
